// File: rtl/blink_bank.sv
// blink_bank: NUM_CH independent LED blink/strobe generators with runtime mode and
// period per channel, one-shot pulses and a global phase sync for blinking channels.
module blink_bank #(
  parameter int          NUM_CH         = 4,
  parameter int          CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 133333333,
  localparam int         CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // Config port: cfg_we_i is a one-cycle write strobe that is always accepted
  // (no ready/backpressure); addresses >= NUM_CH are silently dropped.
  input  logic                  cfg_we_i,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [CNT_W-1:0]      cfg_period_i,
  input  logic                  sync_i,
  output logic [NUM_CH-1:0]     led_o,
  output logic [NUM_CH-1:0]     strb_o,
  output logic [2*NUM_CH-1:0]   mode_o
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_ONESHOT = 2'd3
  } mode_e;

  localparam logic [CNT_W-1:0] RST_PERIOD = CNT_W'(DEFAULT_PERIOD);

  mode_e              mode_q   [NUM_CH];
  mode_e              mode_d   [NUM_CH];
  logic [CNT_W-1:0]   period_q [NUM_CH];
  logic [CNT_W-1:0]   period_d [NUM_CH];
  logic [CNT_W-1:0]   cnt_q    [NUM_CH];
  logic [CNT_W-1:0]   cnt_d    [NUM_CH];
  logic [NUM_CH-1:0]  led_q;
  logic [NUM_CH-1:0]  led_d;
  logic [NUM_CH-1:0]  strb_q;
  logic [NUM_CH-1:0]  strb_d;
  logic [NUM_CH-1:0]  wr_hit;

  // Equality against each in-range index means out-of-range addresses never hit.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      wr_hit[k] = cfg_we_i && (cfg_ch_i == CH_W'(k));
    end
  end

  // Per-channel mode FSM; priority: write > sync > normal mode behaviour.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      mode_d[k]   = mode_q[k];
      period_d[k] = period_q[k];
      cnt_d[k]    = cnt_q[k];
      led_d[k]    = led_q[k];
      strb_d[k]   = 1'b0;
      if (wr_hit[k]) begin
        mode_d[k]   = mode_e'(cfg_mode_i);
        period_d[k] = cfg_period_i;
        cnt_d[k]    = cfg_period_i;
        led_d[k]    = (cfg_mode_i == MODE_ON) || (cfg_mode_i == MODE_ONESHOT);
      end else if (sync_i && (mode_q[k] == MODE_BLINK)) begin
        cnt_d[k] = period_q[k];
        led_d[k] = 1'b0;
      end else begin
        unique case (mode_q[k])
          MODE_OFF: begin
            led_d[k] = 1'b0;
            cnt_d[k] = period_q[k];
          end
          MODE_ON: begin
            led_d[k] = 1'b1;
            cnt_d[k] = period_q[k];
          end
          MODE_BLINK: begin
            if (cnt_q[k] == '0) begin
              cnt_d[k]  = period_q[k];
              strb_d[k] = 1'b1;
              led_d[k]  = ~led_q[k];
            end else begin
              cnt_d[k] = cnt_q[k] - CNT_W'(1);
            end
          end
          MODE_ONESHOT: begin
            if (cnt_q[k] == '0) begin
              cnt_d[k]  = period_q[k];
              strb_d[k] = 1'b1;
              led_d[k]  = 1'b0;
              mode_d[k] = MODE_OFF;
            end else begin
              cnt_d[k] = cnt_q[k] - CNT_W'(1);
              led_d[k] = 1'b1;
            end
          end
          default: begin
            mode_d[k] = MODE_OFF;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mode_q[k]   <= MODE_BLINK;
        period_q[k] <= RST_PERIOD;
        cnt_q[k]    <= RST_PERIOD;
      end
      led_q  <= '0;
      strb_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        mode_q[k]   <= mode_d[k];
        period_q[k] <= period_d[k];
        cnt_q[k]    <= cnt_d[k];
      end
      led_q  <= led_d;
      strb_q <= strb_d;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      mode_o[2*k +: 2] = mode_q[k];
    end
  end

  assign led_o  = led_q;
  assign strb_o = strb_q;

endmodule

// File: tb/tb_blink_bank.sv
// Directed bench for blink_bank (NUM_CH=4, CNT_W=8, DEFAULT_PERIOD=9) plus a 5-channel
// instance used to exercise an out-of-range channel address.
module tb_blink_bank;

  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_ONESHOT = 2'd3;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] ch;
  logic [1:0] mode;
  logic [7:0] period;
  logic       sync;
  logic [3:0] led, strb;
  logic [7:0] mode_o;

  logic       we5;
  logic [2:0] ch5;
  logic [4:0] led5, strb5;
  logic [9:0] mode5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blink_bank #(.NUM_CH(4), .CNT_W(8), .DEFAULT_PERIOD(9)) u_dut (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(we), .cfg_ch_i(ch), .cfg_mode_i(mode),
    .cfg_period_i(period), .sync_i(sync), .led_o(led), .strb_o(strb), .mode_o(mode_o)
  );

  blink_bank #(.NUM_CH(5), .CNT_W(8), .DEFAULT_PERIOD(9)) u_dut5 (
    .clk_i(clk), .rst_i(rst), .cfg_we_i(we5), .cfg_ch_i(ch5), .cfg_mode_i(mode),
    .cfg_period_i(period), .sync_i(sync), .led_o(led5), .strb_o(strb5), .mode_o(mode5)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] c, input logic [1:0] m, input logic [7:0] p);
    we = 1'b1; ch = c; mode = m; period = p;
    step();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; ch = '0; mode = '0; period = '0; sync = 1'b0;
    we5 = 1'b0; ch5 = '0;
    repeat (3) step();                       // R
    chk("rst_led", led, 4'h0);
    chk("rst_strb", strb, 4'h0);
    chk("rst_mode", mode_o, 8'hAA);
    chk("rst_mode5", mode5, 10'h2AA);

    rst = 1'b0; we5 = 1'b1; ch5 = 3'd5; mode = M_OFF; period = 8'd3;
    step();                                  // R+1, out-of-range write
    we5 = 1'b0;
    chk("oor_mode5", mode5, 10'h2AA);
    chk("oor_led5", led5, 5'h00);
    repeat (8) step();                       // R+9
    chk("pre_strb", strb, 4'h0);
    chk("pre_led", led, 4'h0);
    step();                                  // R+10
    chk("first_strb", strb, 4'hF);
    chk("first_led", led, 4'hF);
    chk("oor_strb5", strb5, 5'h1F);
    step();                                  // R+11
    chk("strb_1cyc", strb, 4'h0);
    chk("led_hold", led, 4'hF);
    repeat (9) step();                       // R+20
    chk("second_strb", strb, 4'hF);
    chk("second_led", led, 4'h0);

    wr(2'd1, M_BLINK, 8'd2);                 // E = R+21
    chk("w1_strb", strb, 4'h0);
    chk("w1_mode", mode_o, 8'hAA);
    repeat (2) step();                       // E+2
    chk("w1_e2_strb", strb, 4'h0);
    step();                                  // E+3
    chk("w1_e3_strb", strb, 4'b0010);
    chk("w1_e3_led", led, 4'b0010);
    repeat (3) step();                       // E+6
    chk("w1_e6_strb", strb, 4'b0010);
    chk("w1_e6_led", led, 4'b0000);
    repeat (3) step();                       // E+9 = R+30
    chk("w1_e9_strb", strb, 4'b1111);
    chk("w1_e9_led", led, 4'b1111);

    wr(2'd2, M_ONESHOT, 8'd4);               // E2 = R+31
    chk("os_mode", mode_o[5:4], M_ONESHOT);
    chk("os_led_e1", led, 4'b1111);
    repeat (4) step();                       // R+35
    chk("os_led_e4", led, 4'b1101);
    chk("os_strb_e4", strb, 4'b0000);
    step();                                  // R+36
    chk("os_strb_e5", strb, 4'b0110);
    chk("os_led_e5", led, 4'b1011);
    step();                                  // R+37
    chk("os_mode_off", mode_o[5:4], M_OFF);
    chk("os_strb_e6", strb, 4'b0000);
    repeat (3) step();                       // R+40
    chk("os_no_more", strb, 4'b1001);
    chk("os_led_r40", led, 4'b0000);

    wr(2'd0, M_BLINK, 8'd0);                 // R+41
    chk("p0_strb_w", strb[0], 1'b0);
    chk("p0_led_w", led[0], 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("p0_strb", strb[0], 1'b1);
      chk("p0_led", led[0], (i % 2 == 1) ? 1'b1 : 1'b0);
    end
    wr(2'd0, M_OFF, 8'd5);                   // R+46
    chk("off_led", led[0], 1'b0);
    chk("off_strb", strb[0], 1'b0);
    repeat (3) step();
    chk("off_led_hold", led[0], 1'b0);
    chk("off_strb_hold", strb[0], 1'b0);
    chk("off_mode", mode_o[1:0], M_OFF);

    wr(2'd0, M_BLINK, 8'd9);                 // R+50
    repeat (3) step();
    wr(2'd1, M_BLINK, 8'd9);                 // R+54, ch1 out of phase with ch0
    repeat (2) step();
    sync = 1'b1; we = 1'b1; ch = 2'd3; mode = M_ON; period = 8'd7;
    step();                                  // S
    sync = 1'b0; we = 1'b0;
    chk("sync_led", led, 4'b1000);
    chk("sync_strb", strb, 4'b0000);
    chk("sync_mode", mode_o, 8'h4A);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("sync_quiet", strb, 4'b0000);
    end
    step();                                  // S+10
    chk("sync_strb10", strb, 4'b0011);
    chk("sync_led10", led, 4'b1011);
    repeat (10) step();                      // S+20
    chk("sync_strb20", strb, 4'b0011);
    chk("sync_led20", led, 4'b1000);
    repeat (9) step();
    we = 1'b1; ch = 2'd0; mode = M_BLINK; period = 8'd9;
    step();                                  // S+30: write collides with ch0 expiry
    we = 1'b0;
    chk("wr_vs_exp_strb", strb, 4'b0010);
    chk("wr_vs_exp_led", led, 4'b1010);

    wr(2'd2, M_ONESHOT, 8'd20);
    repeat (3) step();
    rst = 1'b1; we = 1'b1; ch = 2'd1; mode = M_ON; period = 8'd3;
    step();                                  // X
    rst = 1'b0; we = 1'b0;
    chk("rst2_led", led, 4'h0);
    chk("rst2_strb", strb, 4'h0);
    chk("rst2_mode", mode_o, 8'hAA);
    chk("rst2_mode5", mode5, 10'h2AA);
    repeat (9) step();
    chk("rst2_pre_strb", strb, 4'h0);
    step();                                  // X+10
    chk("rst2_strb", strb, 4'hF);
    chk("rst2_led_on", led, 4'hF);
    chk("rst2_strb5", strb5, 5'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
